// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - multiplier launch/result bus between hilo_unit and an external multiplier
//
// Signals:
//   mul_start   : one-cycle launch pulse (unit -> multiplier)
//   mul_a       : latched multiplicand, stable while the multiply is in flight
//   mul_b       : latched multiplier, stable while the multiply is in flight
//   mul_product : unsigned 64-bit product (multiplier -> unit)
// Modports:
//   master : hilo_unit side
//   slave  : multiplier side
interface hilo_unit_if;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_product;

  modport master (
    output mul_start,
    output mul_a,
    output mul_b,
    input  mul_product
  );

  modport slave (
    input  mul_start,
    input  mul_a,
    input  mul_b,
    output mul_product
  );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register pair with a fixed-latency external multiply sequencer
//
// Ports:
//   i_clk, i_reset   : rising-edge clock, synchronous active-high reset
//   i_op_a, i_op_b   : multiply operands, latched when i_mult_req is accepted
//   i_mult_req       : multiply request
//   i_mthi, i_mtlo   : write i_wr_data into HI / LO (IDLE only)
//   i_wr_data        : move data
//   i_mfhi, i_mflo   : read HI / LO onto o_rd_data
//   i_kill           : abort the multiply in flight
//   mul_if           : multiplier bus (master side)
//   o_hi, o_lo       : HI / LO registers
//   o_rd_data        : combinational move-from data
//   o_busy           : multiply in flight
//   o_stall          : requester must hold its request this cycle
//   o_done           : one-cycle pulse on the product capture edge
module hilo_unit #(
  parameter int MUL_LATENCY = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  input  logic        i_mult_req,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic [31:0] i_wr_data,
  input  logic        i_mfhi,
  input  logic        i_mflo,
  input  logic        i_kill,
  hilo_unit_if.master mul_if,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic [31:0] o_rd_data,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  localparam logic [6:0] LAT = 7'(MUL_LATENCY);

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_hi, w_hi_nxt;
  logic [31:0] r_lo, w_lo_nxt;
  logic [31:0] r_mul_a, w_mul_a_nxt;
  logic [31:0] r_mul_b, w_mul_b_nxt;
  logic        r_mul_start, w_mul_start_nxt;
  logic        r_done, w_done_nxt;

  logic        w_idle;
  logic        w_any_req;

  assign w_idle    = (r_state == S_IDLE);
  assign w_any_req = i_mult_req | i_mthi | i_mtlo | i_mfhi | i_mflo;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hi        <= w_hi_nxt;
      r_lo        <= w_lo_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
      r_mul_start <= w_mul_start_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hi_nxt        = r_hi;
    w_lo_nxt        = r_lo;
    w_mul_a_nxt     = r_mul_a;
    w_mul_b_nxt     = r_mul_b;
    w_mul_start_nxt = r_mul_start;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A multiply request wins over a coincident move; the move stalls and retries.
        if (i_mult_req) begin
          w_mul_a_nxt     = i_op_a;
          w_mul_b_nxt     = i_op_b;
          w_mul_start_nxt = 1'b1;
          w_state_nxt     = S_LAUNCH;
        end else begin
          if (i_mthi) w_hi_nxt = i_wr_data;
          if (i_mtlo) w_lo_nxt = i_wr_data;
        end
      end
      S_LAUNCH: begin
        w_mul_start_nxt = 1'b0;
        if (i_kill) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = 7'd1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Kill is checked first so it also suppresses the capture edge.
        if (i_kill) begin
          w_mul_start_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_IDLE;
        end else if (r_cnt == LAT) begin
          w_hi_nxt    = mul_if.mul_product[63:32];
          w_lo_nxt    = mul_if.mul_product[31:0];
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 7'd1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cnt_nxt       = '0;
        w_mul_start_nxt = 1'b0;
      end
    endcase
  end

  assign mul_if.mul_start = r_mul_start;
  assign mul_if.mul_a     = r_mul_a;
  assign mul_if.mul_b     = r_mul_b;

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_done  = r_done;
  assign o_busy  = ~w_idle;
  assign o_stall = (~w_idle & w_any_req) | (w_idle & i_mult_req & (i_mthi | i_mtlo));

  always_comb begin
    o_rd_data = '0;
    if (i_mfhi)      o_rd_data = r_hi;
    else if (i_mflo) o_rd_data = r_lo;
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 32: rising edges from the edge sampling mul_start=1 until the multiplier's product is valid.
REQ-002 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-003 SHALL have these request ports: op_a input 32, multiplicand; op_b input 32, multiplier; mult_req input 1, multiply request.
REQ-004 SHALL have these move ports: mthi input 1, write HI; mtlo input 1, write LO; wr_data input 32, mthi/mtlo data; mfhi input 1, read HI; mflo input 1, read LO; kill input 1, abort multiply.
REQ-005 SHALL have these multiplier ports: mul_product input 64, multiplier result; mul_start output 1, multiplier launch pulse; mul_a output 32, latched multiplicand; mul_b output 32, latched multiplier.
REQ-006 SHALL have these status ports: hi output 32, HI register; lo output 32, LO register; rd_data output 32, mfhi/mflo read data; busy output 1, multiply in flight; stall output 1, hold requester this cycle; done output 1, one-cycle capture pulse.

Function
REQ-007 SHALL implement states IDLE, LAUNCH, WAIT with a 7-bit edge counter cnt; busy = (state != IDLE).
REQ-008 SHALL, in IDLE with mult_req=1 at edge k, latch op_a/op_b into mul_a/mul_b, set mul_start<=1 and enter LAUNCH.
REQ-009 SHALL, in LAUNCH at edge k+1, set mul_start<=0, cnt<=1 and enter WAIT, so mul_start is high exactly one cycle.
REQ-010 SHALL, in WAIT, increment cnt each edge while cnt < MUL_LATENCY.
REQ-011 SHALL, at the WAIT edge where cnt == MUL_LATENCY (edge k+33 at default), set hi<=mul_product[63:32], lo<=mul_product[31:0], done<=1, cnt<=0 and enter IDLE.
REQ-012 SHALL deassert done on every edge other than the capture edge.
REQ-013 SHALL hold mul_a/mul_b stable from edge k until the return to IDLE.
REQ-014 SHALL, in IDLE with mult_req=0, write wr_data to hi on mthi and to lo on mtlo; both asserted writes both registers.
REQ-015 SHALL drive rd_data combinationally: hi when mfhi=1, else lo when mflo=1, else 0; mfhi wins if both are asserted.
REQ-016 SHALL drive stall combinationally = busy & (mult_req | mthi | mtlo | mfhi | mflo), and additionally = 1 in IDLE when mult_req=1 coincides with mthi or mtlo.
REQ-017 SHALL ignore any request raised while stall=1, with no register change; the requester holds it.
REQ-018 SHALL give mult_req priority over mthi/mtlo in the same IDLE cycle; the move is ignored that cycle.
REQ-019 SHALL, on kill=1 in LAUNCH or WAIT, enter IDLE next edge with mul_start<=0 and cnt<=0; hi/lo retained, done not pulsed.
REQ-020 SHALL have no effect from kill in IDLE.
REQ-021 SHALL give kill priority over capture when kill=1 on the cnt == MUL_LATENCY edge.
REQ-022 SHALL treat the product as unsigned 64-bit with no sign extension or truncation.

Reset
REQ-023 SHALL, on reset=1 at any rising edge, set state=IDLE, cnt=0, hi=0, lo=0, mul_a=0, mul_b=0, mul_start=0, done=0.
REQ-024 SHALL give reset priority over kill, capture and all requests.
REQ-025 SHALL drop any multiply in flight on reset, with no capture.
REQ-026 SHALL drive these values after reset: busy=0; stall=0 and rd_data=0 with no requests.

Verification
REQ-027 SHALL cover: mult_req with op_a=3, op_b=5 at edge k -> mul_start high only in cycle k+1; done at edge k+33; hi=0x00000000; lo=0x0000000F; busy=0 after.
REQ-028 SHALL cover: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after capture.
REQ-029 SHALL cover: mfhi held from cycle k+5 -> stall=1 through the capture cycle; next cycle stall=0 and rd_data equals the new hi.
REQ-030 SHALL cover: reset at cnt=10 -> next cycle hi=lo=0, busy=0, mul_start=0; no done within 40 cycles.
REQ-031 SHALL cover: hi=0x12345678 preloaded by mthi, then mult, then kill at cnt=5 -> IDLE next edge, hi=0x12345678, done never asserted.
REQ-032 SHALL cover: IDLE with mult_req and mthi (wr_data=0xA5A5A5A5) same cycle -> stall=1, multiply starts, hi unchanged; mthi retried after capture writes 0xA5A5A5A5.
